// File: rtl/param_mem_pkg.sv
// Shared types and parameter defaults for the parameterised data memory.
package param_mem_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_LATENCY = 1;

  // Legal LATENCY range; the upper bound is what the 4-bit wait counter can hold.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/param_data_mem_wait_counter.sv
// Loadable down-counter timing the WAIT phase of an access.
module wait_counter
  import param_mem_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Load wins over decrement; the count saturates at zero and freezes on stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (enable) begin
      if (load)              cnt <= load_val;
      else if (dec && cnt != '0) cnt <= cnt - W'(1);
    end
  end

  // expire: this decrement takes the count to zero.
  assign zero   = (cnt == '0);
  assign expire = (cnt == W'(1));

endmodule

// File: rtl/param_data_mem.sv
// Single-port data memory with a self-clearing INIT phase, byte-lane writes
// and a fixed, parameterised request-to-ready latency.
module param_data_mem
  import param_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX || (DATA_W % 8) != 0) begin : g_bad_param
    $error("param_data_mem: illegal LATENCY or DATA_W");
  end

  state_e state, state_nxt;

  logic [ADDR_W-1:0] ptr;
  logic              cnt_load, cnt_dec, cnt_zero, cnt_expire;
  logic              acc_fire;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [NB-1:0]     lat_be;
  logic [DATA_W-1:0] lat_wdata;

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [NB-1:0]     acc_be;
  logic [DATA_W-1:0] acc_wdata;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] cur_word, merged;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  wait_counter #(.W(CNT_W)) u_wait_counter (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .expire   (cnt_expire)
  );

  // State register; a stall freezes the FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      state <= ST_INIT;
    else if (enable) state <= state_nxt;
  end

  // Next state; acc_fire marks the edge that completes the access (entering RESP).
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    acc_fire  = 1'b0;
    case (state)
      ST_INIT: if (&ptr) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_nxt = ST_RESP;
            acc_fire  = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_load  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_expire || cnt_zero) begin
          state_nxt = ST_RESP;
          acc_fire  = 1'b1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Clear pointer walks the whole array once per INIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          ptr <= '0;
    else if (enable && state == ST_INIT) ptr <= ptr + ADDR_W'(1);
  end

  // Capture the request at acceptance so later input changes cannot disturb it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
    end else if (enable && state == ST_IDLE && req) begin
      lat_we    <= we;
      lat_addr  <= addr;
      lat_be    <= be;
      lat_wdata <= wdata;
    end
  end

  // With LATENCY=1 the access completes on the accepting edge, so use live inputs in IDLE.
  always_comb begin
    acc_we    = lat_we;
    acc_addr  = lat_addr;
    acc_be    = lat_be;
    acc_wdata = lat_wdata;
    if (state == ST_IDLE) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_be    = be;
      acc_wdata = wdata;
    end
  end

  assign cur_word = mem[acc_addr];

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign merged[i*8 +: 8] = acc_be[i] ? acc_wdata[i*8 +: 8] : cur_word[i*8 +: 8];
  end

  // Single write port shared by the INIT clear and access writes.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = acc_addr;
    mem_wd = merged;
    if (state == ST_INIT) begin
      mem_we = enable;
      mem_wa = ptr;
      mem_wd = '0;
    end else if (acc_fire && acc_we) begin
      mem_we = enable;
    end
  end

  // Storage array: no reset, contents are established by the INIT sweep.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read data updates only when a read completes; writes leave it alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                rdata <= '0;
    else if (enable && acc_fire && !acc_we)    rdata <= cur_word;
  end

  assign ready = (state == ST_RESP);
  assign busy  = (state == ST_INIT);

endmodule

// File: tb/tb_param_data_mem.sv
// Directed bench for param_data_mem: LATENCY=3 main instance, LATENCY=1 side instance.
module tb_param_data_mem;

  logic        clock;
  logic        reset, enable, req, we;
  logic [7:0]  addr;
  logic [1:0]  be;
  logic [15:0] wdata, rdata;
  logic        ready, busy;

  logic        rst1_n, en1, req1, we1;
  logic [7:0]  addr1;
  logic [1:0]  be1;
  logic [15:0] wdata1, rdata1;
  logic        ready1, busy1;

  int errors = 0;
  int checks = 0;
  int n;

  param_data_mem #(.DATA_W(16), .ADDR_W(8), .LATENCY(3)) dut (
    .clock (clock), .reset (reset), .enable (enable), .req (req), .we (we),
    .addr (addr), .be (be), .wdata (wdata), .rdata (rdata), .ready (ready), .busy (busy)
  );

  param_data_mem #(.DATA_W(16), .ADDR_W(8), .LATENCY(1)) dut1 (
    .clock (clock), .reset (rst1_n), .enable (en1), .req (req1), .we (we1),
    .addr (addr1), .be (be1), .wdata (wdata1), .rdata (rdata1), .ready (ready1), .busy (busy1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Count enabled edges until busy drops (bounded).
  task automatic wait_init(output int cnt);
    cnt = 0;
    while (busy !== 1'b0 && cnt < 400) begin
      step();
      cnt++;
    end
  endtask

  // One access on the LATENCY=3 instance: latency counted from the request cycle,
  // inputs scrambled right after acceptance, one-cycle ready pulse checked.
  task automatic access(input logic w, input logic [7:0] a, input logic [1:0] b,
                        input logic [15:0] d, input logic [15:0] exp_rd, input string tag);
    int lat;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    step();
    req = 1'b0; we = ~w; addr = ~a; be = ~b; wdata = ~d;
    lat = 1;
    while (ready !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_rdata"}, rdata, exp_rd);
    step();
    chk({tag, "_pulse"}, ready, 1'b0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; req = 1'b0; we = 1'b0;
    addr = '0; be = '0; wdata = '0;
    rst1_n = 1'b0; en1 = 1'b1; req1 = 1'b0; we1 = 1'b0;
    addr1 = '0; be1 = '0; wdata1 = '0;

    #2;
    chk("rst_busy", busy, 1'b1);
    chk("rst_ready", ready, 1'b0);
    chk("rst_rdata", rdata, 16'h0000);

    step(); step();
    reset = 1'b1; rst1_n = 1'b1;
    wait_init(n);
    chk("init_cycles", n, 256);

    access(1'b0, 8'hFF, 2'b00, 16'h0000, 16'h0000, "rd_ff");
    access(1'b1, 8'h12, 2'b11, 16'hBEEF, 16'h0000, "wr_beef");
    access(1'b0, 8'h12, 2'b00, 16'h0000, 16'hBEEF, "rd_beef");
    access(1'b1, 8'h12, 2'b01, 16'h00AA, 16'hBEEF, "wr_lane0");
    access(1'b0, 8'h12, 2'b00, 16'h0000, 16'hBEAA, "rd_merge");
    access(1'b1, 8'h12, 2'b00, 16'h5555, 16'hBEAA, "wr_be0");
    access(1'b0, 8'h12, 2'b00, 16'h0000, 16'hBEAA, "rd_be0");
    access(1'b1, 8'h13, 2'b11, 16'h1111, 16'hBEAA, "wr_13");
    access(1'b0, 8'h13, 2'b00, 16'h0000, 16'h1111, "rd_13");

    // Stall for 5 cycles in the middle of WAIT.
    req = 1'b1; we = 1'b0; addr = 8'h12;
    step();
    req = 1'b0; addr = 8'h00;
    n = 1;
    step(); n++;
    enable = 1'b0;
    repeat (5) begin
      step(); n++;
    end
    chk("stall_hold", ready, 1'b0);
    enable = 1'b1;
    while (ready !== 1'b1 && n < 40) begin
      step(); n++;
    end
    chk("stall_lat", n, 8);
    chk("stall_rdata", rdata, 16'hBEAA);
    enable = 1'b0;
    repeat (3) step();
    chk("ready_frozen", ready, 1'b1);
    enable = 1'b1;
    step();
    chk("ready_single", ready, 1'b0);

    // Reset in the middle of a write's WAIT.
    access(1'b1, 8'h40, 2'b11, 16'h7777, 16'hBEAA, "wr_40");
    req = 1'b1; we = 1'b1; addr = 8'h40; be = 2'b11; wdata = 16'h1234;
    step();
    req = 1'b0;
    step();
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_rdata", rdata, 16'h0000);
    step();
    reset = 1'b1;
    wait_init(n);
    chk("reinit_cycles", n, 256);
    access(1'b0, 8'h40, 2'b00, 16'h0000, 16'h0000, "rd_40_cleared");

    // LATENCY=1 instance with req held high.
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h05; be1 = 2'b11; wdata1 = 16'hCAFE;
    step();
    chk("l1_wr_ready", ready1, 1'b1);
    we1 = 1'b0; addr1 = 8'h06; wdata1 = 16'h0000;
    step();
    chk("l1_resp_idle", ready1, 1'b0);
    step();
    chk("l1_rd06_ready", ready1, 1'b1);
    chk("l1_rd06_rdata", rdata1, 16'h0000);
    addr1 = 8'h05;
    step();
    chk("l1_gap", ready1, 1'b0);
    step();
    chk("l1_rd05_ready", ready1, 1'b1);
    chk("l1_rd05_rdata", rdata1, 16'hCAFE);
    addr1 = 8'h06;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("l1_alternate", ready1, (k % 2 == 0) ? 1'b0 : 1'b1);
    end
    chk("l1_rd06_again", rdata1, 16'h0000);
    req1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
